fb_mem_arbiter: RTL

- Shares the single-port frame-buffer memory between two requesters:
  - the TMDS pixel read path, which has deadline priority;
  - the frame writer, which loads the next image.
- Manages the two frame banks (display bank and write bank) for double buffering.
- Swaps the banks on the display frame boundary once the writer reports a complete frame.
- Sits between tmds_controller (readrequest/finished side) and the external memory controller.

---
 rtl/fb_mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer arbiter: display reads beat writer writes, double-buffered banks; FB_STARVE_GUARD_EN bounds write starvation.
// Latency: request to mem_req 1 cycle, mem_ack to rd_valid/wr_ack 1 cycle; requesters hold req until their completion pulse.
module fb_mem_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              frame_end,
    input  logic              wr_frame_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              disp_bank,
    output logic              frameswap,
    output logic              swap_pending
);

    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

    state_t state;
    logic   grant_rd;
    logic   grant_wr;

`ifdef FB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    // Once enough reads have overtaken a waiting write, the write takes the next slot.
    assign starve_hit = wr_req && (starve_cnt >= CNT_W'(STARVE_MAX));
    assign grant_rd   = (state == IDLE) && rd_req && !starve_hit;
    assign grant_wr   = (state == IDLE) && wr_req && !grant_rd;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            starve_cnt <= '0;
        end else if (!wr_req || grant_wr) begin
            starve_cnt <= '0;
        end else if (grant_rd && (starve_cnt < CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign grant_rd = (state == IDLE) && rd_req;
    assign grant_wr = (state == IDLE) && wr_req && !rd_req;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            wr_ack       <= 1'b0;
            disp_bank    <= 1'b0;
            frameswap    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            rd_valid  <= 1'b0;
            wr_ack    <= 1'b0;
            frameswap <= 1'b0;

            // Bank bit is captured at issue so a swap never retargets an in-flight access.
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        state    <= RD_BUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {disp_bank, rd_addr};
                    end else if (grant_wr) begin
                        state     <= WR_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {~disp_bank, wr_addr};
                        mem_wdata <= wr_data;
                    end
                end
                RD_BUSY: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        rd_data  <= mem_rdata;
                        rd_valid <= 1'b1;
                    end
                end
                WR_BUSY: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        wr_ack  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            // A frame_end coinciding with wr_frame_done swaps at once; extra done pulses are absorbed.
            if (frame_end && (swap_pending || wr_frame_done)) begin
                disp_bank    <= ~disp_bank;
                frameswap    <= 1'b1;
                swap_pending <= 1'b0;
            end else if (wr_frame_done) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule
